// File: rtl/execute_mul_unit_pkg.sv
// ============================================================================
// Module      : execute_mul_unit_pkg
// Description : Shared encodings and constants for the execute-stage multiplier.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package execute_mul_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } mul_state_t;

   localparam int   MUL_ITERS  = 32;
   localparam int   MUL_CNT_W  = 5;
   localparam logic MUL_SEL_LO = 1'b0;
   localparam logic MUL_SEL_HI = 1'b1;

endpackage

`default_nettype wire

// File: rtl/execute_mul_unit_sign_fix.sv
// ============================================================================
// Module      : mul_sign_fix
// Description : Operand magnitudes, final conditional negate and half select.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mul_sign_fix
   import execute_mul_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   rs2,
   output logic [XLEN-1:0]   abs1,
   output logic [XLEN-1:0]   abs2,
   output logic              op_neg,
   input  logic [2*XLEN-1:0] acc,
   input  logic              neg,
   input  logic              sel,
   output logic [2*XLEN-1:0] product,
   output logic [XLEN-1:0]   result
);

   // The most negative operand maps onto itself and is then read as unsigned.
   assign abs1    = rs1[XLEN-1] ? (~rs1 + XLEN'(1)) : rs1;
   assign abs2    = rs2[XLEN-1] ? (~rs2 + XLEN'(1)) : rs2;
   assign op_neg  = rs1[XLEN-1] ^ rs2[XLEN-1];

   assign product = neg ? (~acc + (2*XLEN)'(1)) : acc;
   assign result  = (sel == MUL_SEL_HI) ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/execute_mul_unit.sv
// ============================================================================
// Module      : execute_mul_unit
// Description : Radix-2 shift-add signed multiplier stalling the front end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module execute_mul_unit
   import execute_mul_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            Mul_i,
   input  logic            Mul_r_i,
   input  logic [XLEN-1:0] Reg1_i,
   input  logic [XLEN-1:0] Reg2_i,
   input  logic [4:0]      RegD_i,
   input  logic            Reg_w_i,
   output logic            stall_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      RegD_o,
   output logic            Reg_w_o,
   output logic            busy_o
);

   mul_state_t             r_state;
   mul_state_t             w_state_nxt;
   logic [XLEN-1:0]        r_mcand;
   logic [XLEN-1:0]        r_mplier;
   logic [2*XLEN-1:0]      r_acc;
   logic [MUL_CNT_W-1:0]   r_cnt;
   logic                   r_neg;
   logic                   r_sel;
   logic [4:0]             r_regd;
   logic                   r_regw;
   logic [XLEN-1:0]        r_result;

   logic [XLEN-1:0]        w_abs1;
   logic [XLEN-1:0]        w_abs2;
   logic                   w_op_neg;
   logic [2*XLEN-1:0]      w_product;
   logic [XLEN-1:0]        w_half;
   logic [XLEN:0]          w_sum;

   mul_sign_fix #(
      .XLEN    (XLEN)
   ) u_sign_fix (
      .rs1     (Reg1_i),
      .rs2     (Reg2_i),
      .abs1    (w_abs1),
      .abs2    (w_abs2),
      .op_neg  (w_op_neg),
      .acc     (r_acc),
      .neg     (r_neg),
      .sel     (r_sel),
      .product (w_product),
      .result  (w_half)
   );

   // Shared adder: the carry becomes the new top bit after the right shift.
   assign w_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      stall_o     = 1'b0;
      valid_o     = 1'b0;
      RegD_o      = '0;
      Reg_w_o     = 1'b0;
      busy_o      = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (Mul_i) begin
               stall_o     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            stall_o = 1'b1;
            if (r_cnt == MUL_CNT_W'(MUL_ITERS - 1)) w_state_nxt = SIGN;
         end
         SIGN: begin
            stall_o     = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            valid_o     = 1'b1;
            RegD_o      = r_regd;
            Reg_w_o     = r_regw;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_sel    <= 1'b0;
         r_regd   <= '0;
         r_regw   <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Mul_i) begin
                  r_mcand  <= w_abs1;
                  r_mplier <= w_abs2;
                  r_neg    <= w_op_neg;
                  r_sel    <= Mul_r_i;
                  r_regd   <= RegD_i;
                  r_regw   <= Reg_w_i;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            RUN: begin
               r_acc    <= {w_sum, r_acc[XLEN-1:1]};
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + MUL_CNT_W'(1);
            end
            SIGN: begin
               r_acc    <= w_product;
               r_result <= w_half;
            end
            default: ;
         endcase
      end
   end

   assign result_o = r_result;

endmodule

`default_nettype wire

// File: doc/execute_mul_unit.md
# execute_mul_unit

Multi-cycle signed multiplier in the execute stage, consuming the multiply fields from the decode/execute pipeline register (`Mul_o`, `Mul_r_o`, `Reg1_o`, `Reg2_o`, `RegD_o`, `Reg_w_o`). It accepts one multiply per request, holds the front of the pipeline via `stall_o` while it iterates, and presents a 32-bit result with its destination register for writeback. It is a radix-2 shift-add engine; a single adder is shared across iterations.

## Interface
- Parameters:
  - `XLEN`, default 32: operand and result width.
- Ports:
  - `clk_i`, input, 1: clock. Every state update happens on the rising edge.
  - `reset_i`, input, 1: reset, synchronous and active-high.
  - `Mul_i`, input, 1: the instruction in execute is a multiply.
  - `Mul_r_i`, input, 1: result select. 0 returns product[31:0] (MUL); 1 returns product[63:32] (MULH, signed×signed).
  - `Reg1_i`, input, 32: multiplicand (rs1).
  - `Reg2_i`, input, 32: multiplier (rs2).
  - `RegD_i`, input, 5: destination register.
  - `Reg_w_i`, input, 1: register-write enable of the instruction.
  - `stall_o`, output, 1: freeze PC, IF/ID and decode/execute registers.
  - `valid_o`, output, 1: `result_o` is valid this cycle.
  - `result_o`, output, 32: selected product half.
  - `RegD_o`, output, 5: latched destination.
  - `Reg_w_o`, output, 1: latched write enable, qualified by `valid_o`.
  - `busy_o`, output, 1: the unit is not in IDLE.

## Operation
- States are IDLE, RUN, SIGN and DONE.
- **IDLE**
  - When `Mul_i`=1: latch |Reg1|, |Reg2|, the sign flag `neg` = Reg1[31]^Reg2[31], `Mul_r_i`, `RegD_i` and `Reg_w_i`.
  - On the same edge: clear the 64-bit accumulator, clear the 5-bit counter and go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each cycle:
  - If multiplier bit 0 = 1, add the multiplicand into accumulator[63:32] with a 33-bit sum, keeping the carry.
  - Shift {carry, acc} right by 1 and shift the multiplier right by 1.
  - Increment the counter. When counter = 31, go to SIGN.
- **SIGN**
  - If `neg`=1, replace the accumulator with its two's complement (64-bit), otherwise keep it.
  - Select the half per the latched `Mul_r`. Go to DONE.
- **DONE**
  - `valid_o`=1; `result_o`, `RegD_o` and `Reg_w_o` are driven from the latched values. Go to IDLE.
  - `Mul_i` is ignored in DONE, because the decode/execute register still holds the same instruction.
- `stall_o` = (IDLE && `Mul_i`) || RUN || SIGN. This is combinational, so the request cycle itself stalls.
- Absolute value of 0x80000000 is 0x80000000, treated as unsigned. The product stays exact in 64 bits.
- Reset (any state, including mid-RUN) forces IDLE and clears the accumulator, counter and all latched fields. An in-flight result is discarded and no `valid_o` is produced.
- `Reg_w_o` and `RegD_o` are 0 whenever `valid_o`=0.

## Timing
- Values after reset: `stall_o`=0, `valid_o`=0, `result_o`=0, `RegD_o`=0, `Reg_w_o`=0, `busy_o`=0.
- For a request seen in IDLE at cycle N:
  - `stall_o`=1 for cycles N through N+33 (N, 32 RUN cycles, 1 SIGN cycle).
  - `valid_o`=1 in cycle N+34 only, with `stall_o`=0 in that cycle.
  - The pipeline advances on the edge ending N+34.
- Total occupancy is 35 cycles per multiply.
- Back-to-back multiplies: the next `Mul_i` is sampled in IDLE at N+35, so there is no dead cycle beyond DONE.
- `result_o` holds its value until the next DONE; only `valid_o` qualifies it.
- Reset asserted in cycle k means outputs are at reset values from cycle k+1.

## Structure
- Shared pipeline package:
  - state encoding `mul_state_t` (IDLE=2'd0, RUN=2'd1, SIGN=2'd2, DONE=2'd3);
  - constant `MUL_ITERS`=32;
  - `MUL_SEL_LO`=0 and `MUL_SEL_HI`=1.
- One sub-module is natural: `mul_sign_fix`, which is combinational. It handles operand absolute value, the final conditional 64-bit negate and the half select. The FSM, datapath registers and counter stay in `execute_mul_unit`.

## Test plan
- Reg1=7, Reg2=6, `Mul_r`=0 → `stall_o` high for exactly 34 cycles; `valid_o` 1 cycle later with `result_o`=42 and `RegD_o`/`Reg_w_o` equal to the latched values.
- Reg1=0xFFFFFFFD (-3), Reg2=5 → `Mul_r`=0 gives 0xFFFFFFF1; `Mul_r`=1 gives 0xFFFFFFFF.
- Reg1=Reg2=0x80000000 → `Mul_r`=1 gives 0x40000000; `Mul_r`=0 gives 0x00000000.
- Two consecutive multiplies, 3×4 then 0x10000×0x10000 with `Mul_r`=1 → results 12 and 0x00000001, with `valid_o` pulses 35 cycles apart.
- `reset_i` for one cycle at RUN iteration 10 → outputs at reset values next cycle, no `valid_o`, `busy_o`=0. A new request afterwards completes normally.
- `Mul_i`=0 with arbitrary operands for 50 cycles → `stall_o`, `busy_o` and `valid_o` stay 0.
